// File: rtl/vidya_timing_pkg.sv
// Video timing package: mode descriptor type, resolution table and lookup.
//   mode_t   : active/porch/sync lengths for both axes plus sync polarities
//              (pol = 1 means the sync pulse is driven high).
//   MODE_TBL : entries 0..2 are 640x480, 800x600, 1280x720; entry 3 is
//              reserved and holds a copy of 640x480.
//   get_mode : resolution select to descriptor, with 3 folded onto 0.
package vidya_timing_pkg;

    localparam int unsigned MODE_CNT_W = 12;

    typedef struct packed {
        logic [MODE_CNT_W-1:0] h_act;
        logic [MODE_CNT_W-1:0] h_fp;
        logic [MODE_CNT_W-1:0] h_sync;
        logic [MODE_CNT_W-1:0] h_bp;
        logic [MODE_CNT_W-1:0] v_act;
        logic [MODE_CNT_W-1:0] v_fp;
        logic [MODE_CNT_W-1:0] v_sync;
        logic [MODE_CNT_W-1:0] v_bp;
        logic                  h_pol;
        logic                  v_pol;
    } mode_t;

    localparam mode_t MODE_TBL [4] = '{
        '{12'd640,  12'd16,  12'd96,  12'd48,  12'd480, 12'd10, 12'd2, 12'd33, 1'b0, 1'b0},
        '{12'd800,  12'd40,  12'd128, 12'd88,  12'd600, 12'd1,  12'd4, 12'd23, 1'b1, 1'b1},
        '{12'd1280, 12'd110, 12'd40,  12'd220, 12'd720, 12'd5,  12'd5, 12'd20, 1'b1, 1'b1},
        '{12'd640,  12'd16,  12'd96,  12'd48,  12'd480, 12'd10, 12'd2, 12'd33, 1'b0, 1'b0}
    };

    function automatic mode_t get_mode(input logic [1:0] res);
        return (res == 2'd3) ? MODE_TBL[0] : MODE_TBL[res];
    endfunction

endpackage

// File: rtl/video_timing_gen.sv
// Raster timing generator for the TMDS output path (pixel clock domain).
// Ports:
//   clk, rst        pixel clock, synchronous active-high reset
//   res             resolution select, taken at frame boundaries only
//   pix_in/valid    upstream pixel stream; pix_ready marks a consumed slot
//   underflow_clr   clears the sticky underflow flag
//   rgb_out, de     pixel and data-enable to the encoders
//   hsync, vsync    syncs in the current mode's polarity
//   x, y            counter position of the pixel on rgb_out
//   frame_start     one-cycle pulse alongside pixel (0,0)
//   underflow       sticky: a slot was consumed with pix_valid low
module video_timing_gen
    import vidya_timing_pkg::*;
#(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned CNT_W  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        res,
    input  logic [DATA_W-1:0] pix_in,
    input  logic              pix_valid,
    output logic              pix_ready,
    input  logic              underflow_clr,
    output logic [DATA_W-1:0] rgb_out,
    output logic              de,
    output logic              hsync,
    output logic              vsync,
    output logic [CNT_W-1:0]  x,
    output logic [CNT_W-1:0]  y,
    output logic              frame_start,
    output logic              underflow
);

    mode_t            mode_r;
    mode_t            res_mode;
    logic [CNT_W-1:0] h_cnt, v_cnt;
    logic [CNT_W-1:0] h_max, v_max;
    logic [CNT_W-1:0] hs_beg, hs_end, vs_beg, vs_end;
    logic             h_last, v_last;
    logic             in_hs, in_vs;

    always_comb begin
        res_mode  = get_mode(res);
        h_max     = mode_r.h_act + mode_r.h_fp + mode_r.h_sync + mode_r.h_bp - CNT_W'(1);
        v_max     = mode_r.v_act + mode_r.v_fp + mode_r.v_sync + mode_r.v_bp - CNT_W'(1);
        hs_beg    = mode_r.h_act + mode_r.h_fp;
        hs_end    = hs_beg + mode_r.h_sync;
        vs_beg    = mode_r.v_act + mode_r.v_fp;
        vs_end    = vs_beg + mode_r.v_sync;
        h_last    = (h_cnt == h_max);
        v_last    = (v_cnt == v_max);
        in_hs     = (h_cnt >= hs_beg) && (h_cnt < hs_end);
        in_vs     = (v_cnt >= vs_beg) && (v_cnt < vs_end);
        pix_ready = (h_cnt < mode_r.h_act) && (v_cnt < mode_r.v_act);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_r      <= res_mode;
            h_cnt       <= '0;
            v_cnt       <= '0;
            de          <= 1'b0;
            rgb_out     <= '0;
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
            hsync       <= ~res_mode.h_pol;
            vsync       <= ~res_mode.v_pol;
        end else begin
            // Mode swaps on the last pixel of the frame so the new timing
            // takes effect exactly when the counters return to (0,0).
            if (h_last && v_last)
                mode_r <= res_mode;

            if (h_last) begin
                h_cnt <= '0;
                v_cnt <= v_last ? '0 : v_cnt + CNT_W'(1);
            end else begin
                h_cnt <= h_cnt + CNT_W'(1);
            end

            de          <= pix_ready;
            rgb_out     <= (pix_ready && pix_valid) ? pix_in : '0;
            x           <= h_cnt;
            y           <= v_cnt;
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
            hsync       <= in_hs ? mode_r.h_pol : ~mode_r.h_pol;
            vsync       <= in_vs ? mode_r.v_pol : ~mode_r.v_pol;

            if (pix_ready && !pix_valid)
                underflow <= 1'b1;
            else if (underflow_clr)
                underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
module tb_video_timing_gen;

    localparam int DATA_W = 24;
    localparam int CNT_W  = 12;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [1:0]        res = 2'd0;
    logic [DATA_W-1:0] pix_in = '0;
    logic              pix_valid = 1'b1;
    logic              pix_ready;
    logic              underflow_clr = 1'b0;
    logic [DATA_W-1:0] rgb_out;
    logic              de, hsync, vsync, frame_start, underflow;
    logic [CNT_W-1:0]  x, y;

    always #5 clk = ~clk;

    video_timing_gen #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .res(res),
        .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .underflow_clr(underflow_clr),
        .rgb_out(rgb_out), .de(de), .hsync(hsync), .vsync(vsync),
        .x(x), .y(y), .frame_start(frame_start), .underflow(underflow)
    );

    // Reference timing: lengths straight from the mode table.
    int HA [3] = '{640, 800, 1280};
    int HF [3] = '{16, 40, 110};
    int HS [3] = '{96, 128, 40};
    int HB [3] = '{48, 88, 220};
    int VA [3] = '{480, 600, 720};
    int VF [3] = '{10, 1, 5};
    int VS [3] = '{2, 4, 5};
    int VB [3] = '{33, 23, 20};
    int POL[3] = '{0, 1, 1};

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: raster position, active mode index, underflow flag.
    int mh = 0, mv = 0, mm = 0, mu = 0;
    bit pattern_en = 0;
    bit drops_en   = 1;

    function automatic int midx(input int r);
        return (r == 3) ? 0 : r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (model x=%0d y=%0d)", tag, got, exp, mh, mv);
        end
    endtask

    // Choose inputs for the coming cycle from the model's raster position.
    task automatic drive();
        if (pattern_en)
            pix_in = DATA_W'(((mv & 'hff) << 16) | (mh & 'hffff));
        else
            pix_in = DATA_W'($urandom);
        pix_valid     = drops_en ? ($urandom_range(0, 15) != 0) : 1'b1;
        underflow_clr = ($urandom_range(0, 63) == 0);
        if (mv == 5 && mh >= 10 && mh <= 12)
            pix_valid = 1'b0;
        if (mv == 5 && mh == 12)
            underflow_clr = 1'b1;
    endtask

    // One clock: predict registered outputs, clock, compare, advance model.
    task automatic step();
        int htot, vtot, nm, p;
        bit rdy;
        logic [DATA_W-1:0] e_rgb;
        bit e_de, e_hs, e_vs, e_fs, e_u;
        int e_x, e_y;

        if (rst) begin
            p = POL[midx(int'(res))];
            e_de = 0; e_rgb = '0; e_x = 0; e_y = 0; e_fs = 0; e_u = 0;
            e_hs = !p; e_vs = !p;
        end else begin
            rdy   = (mh < HA[mm]) && (mv < VA[mm]);
            e_de  = rdy;
            e_rgb = (rdy && pix_valid) ? pix_in : '0;
            e_x   = mh;
            e_y   = mv;
            e_fs  = (mh == 0) && (mv == 0);
            e_hs  = (mh >= HA[mm] + HF[mm] && mh < HA[mm] + HF[mm] + HS[mm]) ? POL[mm] : !POL[mm];
            e_vs  = (mv >= VA[mm] + VF[mm] && mv < VA[mm] + VF[mm] + VS[mm]) ? POL[mm] : !POL[mm];
            e_u   = (rdy && !pix_valid) ? 1'b1 : (underflow_clr ? 1'b0 : mu[0]);
        end

        @(posedge clk);
        #1;
        check("de", de, e_de);
        check("rgb_out", rgb_out, e_rgb);
        check("x", x, e_x);
        check("y", y, e_y);
        check("hsync", hsync, e_hs);
        check("vsync", vsync, e_vs);
        check("frame_start", frame_start, e_fs);
        check("underflow", underflow, e_u);
        mu = e_u;

        if (rst) begin
            mh = 0; mv = 0; mm = midx(int'(res));
        end else begin
            htot = HA[mm] + HF[mm] + HS[mm] + HB[mm];
            vtot = VA[mm] + VF[mm] + VS[mm] + VB[mm];
            nm = mm;
            if (mh == htot - 1 && mv == vtot - 1)
                nm = midx(int'(res));
            mh++;
            if (mh == htot) begin
                mh = 0;
                mv++;
                if (mv == vtot) mv = 0;
            end
            mm = nm;
        end
        check("pix_ready", pix_ready, (mh < HA[mm]) && (mv < VA[mm]));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            drive();
            step();
        end
    endtask

    // Skip ahead vertically so late-frame timing is reachable in few cycles.
    task automatic jump_v(input int k);
        force dut.v_cnt = CNT_W'(k);
        #1;
        release dut.v_cnt;
        mv = k;
    endtask

    task automatic do_reset(input logic [1:0] r, input int cycles);
        rst = 1'b1;
        res = r;
        for (int i = 0; i < cycles; i++) begin
            drive();
            step();
        end
        rst = 1'b0;
    endtask

    initial begin
        // Mode 0: reset, start of frame, late-frame vsync region.
        do_reset(2'd0, 3);
        run(1700);
        jump_v(488);
        run(800 * 3);
        res = 2'd2;
        run(800 * 3);
        res = 2'd1;
        run(800 * 2);
        // Frame wrap into mode 1 (last res value before the boundary wins).
        jump_v(523);
        run(1600 + 2 * 1056 + 100);

        // Forced misses at x=10..12 on line 5, plus clear colliding with a miss.
        for (int i = 0; i < 8000 && mv < 6; i++) begin
            drive();
            step();
        end
        check("reach_line6", mv, 6);

        // Reset mid-frame at (300,200) in mode 1.
        jump_v(198);
        for (int i = 0; i < 4000 && !(mv == 200 && mh == 300); i++) begin
            drive();
            step();
        end
        check("reach_x300", mh, 300);
        do_reset(2'd1, 2);
        run(2200);

        // Mode 2 with a coordinate-coded pixel stream.
        pattern_en = 1;
        drops_en   = 0;
        do_reset(2'd2, 2);
        run(1650 * 3);
        jump_v(718);
        run(1650 * 3);
        pattern_en = 0;
        drops_en   = 1;

        // Reserved select behaves as mode 0.
        do_reset(2'd3, 2);
        run(1700);
        jump_v(488);
        run(800 * 4);
        jump_v(523);
        run(1700);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
